// File: rtl/accum_launcher.sv
// Job sequencer in front of the accumulate core: queues (init_i, init_acc) jobs,
// pulses the core start, waits for its done level and returns the result or a timeout.
module accum_launcher #(
    parameter int unsigned JOB_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           job_valid,
    output logic                           job_ready,
    input  logic [63:0]                    job_i,
    input  logic [63:0]                    job_acc,
    output logic                           core_r_enable,
    output logic [63:0]                    core_init_i,
    output logic [63:0]                    core_init_acc,
    input  logic                           core_w_enable,
    input  logic [63:0]                    core_result,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [63:0]                    res_data,
    output logic                           res_timeout,
    output logic                           busy,
    output logic [$clog2(JOB_DEPTH):0]     job_count
);

    localparam int unsigned AW = $clog2(JOB_DEPTH);
    localparam int unsigned CW = $clog2(JOB_DEPTH) + 1;
    localparam int unsigned TW = 32;

    typedef struct packed {
        logic [63:0] init_i;
        logic [63:0] init_acc;
    } job_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    job_t            mem_q [JOB_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [TW-1:0]   tmr_q;

    logic            push, pop, cap_done, cap_timeout, timeout_hit;

    assign job_ready   = (count_q != CW'(JOB_DEPTH));
    assign job_count   = count_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0);
    assign push        = job_valid && job_ready;
    assign timeout_hit = (tmr_q == TW'(TIMEOUT - 1));

    // Next-state and per-cycle strobes
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                // A done level seen in the same cycle as the timeout takes priority
                if (core_w_enable) begin
                    cap_done = 1'b1;
                    state_d  = S_DONE;
                end else if (timeout_hit) begin
                    cap_timeout = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (res_valid && res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Job storage carries no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{init_i: job_i, init_acc: job_acc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else if (state_q == S_LAUNCH) begin
            tmr_q <= '0;
        end else if (state_q == S_WAIT) begin
            tmr_q <= tmr_q + TW'(1);
        end
    end

    // Registered core-side and result-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_r_enable <= 1'b0;
            core_init_i   <= '0;
            core_init_acc <= '0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_timeout   <= 1'b0;
        end else begin
            core_r_enable <= (state_d == S_LAUNCH);
            if (pop) begin
                core_init_i   <= mem_q[rd_ptr_q].init_i;
                core_init_acc <= mem_q[rd_ptr_q].init_acc;
            end
            if (cap_done) begin
                res_valid   <= 1'b1;
                res_data    <= core_result;
                res_timeout <= 1'b0;
            end else if (cap_timeout) begin
                res_valid   <= 1'b1;
                res_data    <= '0;
                res_timeout <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accum_launcher.sv
// Directed bench for accum_launcher with a behavioural core stub (done after k WAIT cycles).
module tb_accum_launcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [63:0] job_i = '0;
    logic [63:0] job_acc = '0;
    logic        core_r_enable;
    logic [63:0] core_init_i, core_init_acc;
    logic        core_w_enable = 1'b0;
    logic [63:0] core_result = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
    logic        res_timeout;
    logic        busy;
    logic [2:0]  job_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          lq_cyc[$];
    logic [63:0] lq_i[$];
    logic [63:0] lq_acc[$];

    int          stub_k = 0;
    logic [63:0] stub_res = '0;
    int          scnt = 0;
    bit          sactive = 1'b0;
    logic [63:0] sacc = '0;

    accum_launcher #(.JOB_DEPTH(4), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_i(job_i), .job_acc(job_acc),
        .core_r_enable(core_r_enable), .core_init_i(core_init_i), .core_init_acc(core_init_acc),
        .core_w_enable(core_w_enable), .core_result(core_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_timeout(res_timeout), .busy(busy), .job_count(job_count)
    );

    always #5 clk = ~clk;

    // Edge counter and launch log; a logged edge is the one that ends LAUNCH
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_r_enable) begin
            lq_cyc.push_back(cyc + 1);
            lq_i.push_back(core_init_i);
            lq_acc.push_back(core_init_acc);
        end
    end

    // Core stub: clears done on start, raises it so WAIT sees it on its k-th cycle
    always @(posedge clk) begin
        if (core_r_enable) begin
            core_w_enable <= 1'b0;
            scnt          <= 1;
            sactive       <= 1'b1;
            sacc          <= core_init_acc;
        end else if (sactive) begin
            if (stub_k > 1 && scnt == stub_k - 1) begin
                core_w_enable <= 1'b1;
                core_result   <= stub_res ^ sacc;
                sactive       <= 1'b0;
            end
            scnt <= scnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        lq_cyc.delete();
        lq_i.delete();
        lq_acc.delete();
    endtask

    task automatic push(input logic [63:0] i, input logic [63:0] acc, output int acc_cyc);
        job_valid = 1'b1;
        job_i     = i;
        job_acc   = acc;
        acc_cyc   = -1;
        for (int n = 0; n < 100; n++) begin
            if (job_ready) begin
                tick();
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        job_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (res_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        ok = res_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (job_ready !== 1'b1)     begin errors++; $display("FAIL reset job_ready got %b want 1", job_ready); end
        checks++; if (job_count !== 3'd0)     begin errors++; $display("FAIL reset job_count got %0d want 0", job_count); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset busy got %b want 0", busy); end
        checks++; if (core_r_enable !== 1'b0) begin errors++; $display("FAIL reset r_enable got %b want 0", core_r_enable); end
        checks++; if (core_init_i !== 64'd0)  begin errors++; $display("FAIL reset init_i got %h want 0", core_init_i); end
        checks++; if (core_init_acc !== 64'd0) begin errors++; $display("FAIL reset init_acc got %h want 0", core_init_acc); end
        checks++; if (res_valid !== 1'b0)     begin errors++; $display("FAIL reset res_valid got %b want 0", res_valid); end
        checks++; if (res_data !== 64'd0)     begin errors++; $display("FAIL reset res_data got %h want 0", res_data); end
        checks++; if (res_timeout !== 1'b0)   begin errors++; $display("FAIL reset res_timeout got %b want 0", res_timeout); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int e;
        bit ok;
        clear_log();
        stub_k   = 10;
        stub_res = 64'h1231;
        push(64'd0, 64'd5, e);
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single res_valid never rose"); end
        checks++; if (cyc !== e + 12) begin errors++; $display("FAIL single latency got %0d want %0d", cyc - e, 12); end
        checks++; if (lq_cyc.size() !== 1) begin errors++; $display("FAIL single launches got %0d want 1", lq_cyc.size()); end
        if (lq_cyc.size() > 0) begin
            checks++; if (lq_cyc[0] !== e + 2) begin errors++; $display("FAIL single launch edge got %0d want %0d", lq_cyc[0], e + 2); end
            checks++; if (lq_i[0] !== 64'd0 || lq_acc[0] !== 64'd5) begin errors++; $display("FAIL single init got %h/%h want 0/5", lq_i[0], lq_acc[0]); end
        end
        checks++; if (res_data !== 64'h1234 || res_timeout !== 1'b0) begin errors++; $display("FAIL single result got %h/%b want 1234/0", res_data, res_timeout); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single after handshake valid/busy got %b/%b want 0/0", res_valid, busy); end
    endtask

    task automatic test_fifo_fill();
        int e;
        clear_log();
        stub_k = 0;
        for (int n = 0; n < 5; n++) push(64'(10 + n), 64'(100 + n), e);
        checks++; if (job_count !== 3'd4) begin errors++; $display("FAIL fill job_count got %0d want 4", job_count); end
        checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL fill job_ready got %b want 0", job_ready); end
        job_valid = 1'b1;
        job_i     = 64'd99;
        job_acc   = 64'd99;
        tick(); tick(); tick();
        job_valid = 1'b0;
        checks++; if (job_count !== 3'd4 || job_ready !== 1'b0) begin errors++; $display("FAIL fill push_while_full count/ready got %0d/%b want 4/0", job_count, job_ready); end
        stub_k    = 3;
        stub_res  = 64'h0;
        res_ready = 1'b1;
        for (int n = 0; n < 600 && (busy || lq_cyc.size() < 5); n++) tick();
        res_ready = 1'b0;
        checks++; if (lq_cyc.size() !== 5 || busy !== 1'b0) begin errors++; $display("FAIL fill drain launches/busy got %0d/%b want 5/0", lq_cyc.size(), busy); end
        for (int n = 0; n < 5 && n < lq_cyc.size(); n++) begin
            checks++;
            if (lq_i[n] !== 64'(10 + n) || lq_acc[n] !== 64'(100 + n)) begin
                errors++;
                $display("FAIL fill order[%0d] got %0d/%0d want %0d/%0d", n, lq_i[n], lq_acc[n], 10 + n, 100 + n);
            end
        end
    endtask

    task automatic test_stale_done();
        int e;
        bit ok;
        clear_log();
        stub_k   = 4;
        stub_res = 64'hBEED;
        push(64'd1, 64'd2, e);
        wait_valid(ok);
        checks++; if (!ok || cyc !== e + 6) begin errors++; $display("FAIL stale completion edge got %0d want %0d", cyc - e, 6); end
        checks++; if (res_data !== 64'hBEEF || res_timeout !== 1'b0) begin errors++; $display("FAIL stale result got %h/%b want beef/0", res_data, res_timeout); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int e;
        bit ok;
        clear_log();
        stub_k = 0;
        push(64'd7, 64'd8, e);
        wait_valid(ok);
        checks++; if (!ok || cyc !== e + 22) begin errors++; $display("FAIL timeout edge got %0d want %0d", cyc - e, 22); end
        checks++; if (res_timeout !== 1'b1 || res_data !== 64'd0) begin errors++; $display("FAIL timeout result got %h/%b want 0/1", res_data, res_timeout); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        stub_k   = 5;
        stub_res = 64'h5C;
        push(64'd9, 64'd9, e);
        wait_valid(ok);
        checks++; if (lq_cyc.size() !== 2) begin errors++; $display("FAIL timeout relaunch count got %0d want 2", lq_cyc.size()); end
        checks++; if (!ok || cyc !== e + 7 || res_data !== 64'h55 || res_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout next_job edge/data/to got %0d/%h/%b want 7/55/0", cyc - e, res_data, res_timeout);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int e, e2, h;
        bit ok;
        clear_log();
        stub_k   = 2;
        stub_res = 64'hA0;
        push(64'd1, 64'h10, e);
        push(64'd2, 64'h20, e2);
        wait_valid(ok);
        checks++; if (!ok || cyc !== e + 4) begin errors++; $display("FAIL bp first edge got %0d want %0d", cyc - e, 4); end
        for (int n = 0; n < 7; n++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== 64'hB0 || lq_cyc.size() !== 1) begin
                errors++;
                $display("FAIL bp hold[%0d] valid/data/launches got %b/%h/%0d want 1/b0/1", n, res_valid, res_data, lq_cyc.size());
            end
        end
        res_ready = 1'b1;
        tick();
        h = cyc;
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp handshake valid got %b want 0", res_valid); end
        tick();
        tick();
        checks++; if (lq_cyc.size() !== 2 || lq_cyc[lq_cyc.size()-1] !== h + 2) begin
            errors++; $display("FAIL bp relaunch launches/edge got %0d/%0d want 2/%0d", lq_cyc.size(), lq_cyc[lq_cyc.size()-1], h + 2);
        end
        wait_valid(ok);
        checks++; if (!ok || res_data !== 64'h80 || lq_i[1] !== 64'd2) begin errors++; $display("FAIL bp second result got %h init_i %0d want 80/2", res_data, lq_i[1]); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int e;
        bit ok;
        clear_log();
        stub_k = 0;
        push(64'd3, 64'd30, e);
        push(64'd4, 64'd40, e);
        push(64'd5, 64'd50, e);
        tick(); tick(); tick();
        checks++; if (job_count !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL rst precondition count/busy got %0d/%b want 2/1", job_count, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (job_count !== 3'd0 || job_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst async count/ready/busy got %0d/%b/%b want 0/1/0", job_count, job_ready, busy);
        end
        checks++; if (core_r_enable !== 1'b0 || core_init_i !== 64'd0 || core_init_acc !== 64'd0) begin
            errors++; $display("FAIL rst async core got %b/%h/%h want 0/0/0", core_r_enable, core_init_i, core_init_acc);
        end
        checks++; if (res_valid !== 1'b0 || res_data !== 64'd0 || res_timeout !== 1'b0) begin
            errors++; $display("FAIL rst async result got %b/%h/%b want 0/0/0", res_valid, res_data, res_timeout);
        end
        tick();
        rst_n = 1'b1;
        clear_log();
        repeat (10) tick();
        checks++; if (lq_cyc.size() !== 0 || job_count !== 3'd0) begin errors++; $display("FAIL rst idle launches/count got %0d/%0d want 0/0", lq_cyc.size(), job_count); end
        stub_k   = 3;
        stub_res = 64'h70;
        push(64'd5, 64'd3, e);
        wait_valid(ok);
        checks++; if (!ok || cyc !== e + 5 || res_data !== 64'h73 || lq_i.size() !== 1) begin
            errors++; $display("FAIL rst new_job edge/data/launches got %0d/%h/%0d want 5/73/1", cyc - e, res_data, lq_i.size());
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_fill();
        test_stale_done();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accum_launcher.md
# accum_launcher

Job sequencer that sits directly upstream of the synthesised accumulate core (`main`) and drives its start/result protocol. Jobs `(init_i, init_acc)` are buffered in a small FIFO. The core is started with a single-cycle `r_enable` pulse, and the block waits for the core's `w_enable`. The captured 64-bit result is returned on a valid/ready output, and a timeout is flagged if the core never finishes.

## Interface
Parameters:
- `JOB_DEPTH`, default 4: job FIFO depth; must be a power of two, ≥ 2.
- `TIMEOUT`, default 65535: maximum cycles spent in WAIT before aborting; 32-bit; must be ≥ 1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `job_valid`  in  1: upstream job offered.
- `job_ready`  out  1: FIFO can accept; equals `!full`.
- `job_i`  in  64: initial loop index for the core.
- `job_acc`  in  64: initial accumulator for the core.
- `core_r_enable`  out  1: start pulse to core `r_enable`.
- `core_init_i`  out  64: registered, to core `init_i`.
- `core_init_acc`  out  64: registered, to core `init_acc`.
- `core_w_enable`  in  1: core done flag; level-held until the next start.
- `core_result`  in  64: core result, valid while `core_w_enable` is high.
- `res_valid`  out  1: result available downstream.
- `res_ready`  in  1: downstream accepts.
- `res_data`  out  64: captured result; 0 on timeout.
- `res_timeout`  out  1: qualifies `res_data`; 1 means the job aborted.
- `busy`  out  1: high in any state other than IDLE, or while the FIFO is non-empty.
- `job_count`  out  $clog2(JOB_DEPTH)+1: FIFO occupancy.

## Operation
- **FIFO**
  - Push on `job_valid && job_ready`. Pop only on the IDLE→LAUNCH transition.
  - When full, `job_ready` is 0; there is no same-cycle push-while-full bypass.
  - Push and pop in the same cycle leaves `job_count` unchanged.
  - Pointers wrap modulo `JOB_DEPTH`.
- **FSM states:** IDLE, LAUNCH, WAIT, DONE.
  - IDLE: if the FIFO is non-empty, pop the head into `core_init_i`/`core_init_acc`, then go to LAUNCH.
  - LAUNCH: `core_r_enable` = 1 for exactly this one cycle; clear the timeout counter; go to WAIT.
  - WAIT: the counter increments each cycle.
    - If `core_w_enable` = 1: capture `core_result` into `res_data`, set `res_timeout` = 0, go to DONE.
    - Otherwise, if the counter reaches `TIMEOUT`: set `res_data` = 0, set `res_timeout` = 1, go to DONE.
    - If both conditions hold in the same cycle, completion wins.
  - DONE: `res_valid` = 1, with `res_data`/`res_timeout` held stable. On `res_valid && res_ready`, go to IDLE.
- `core_w_enable` is ignored outside WAIT. The core's stale high level from a previous job must never complete a new job.
  - The core clears `w_enable` on the same edge that ends LAUNCH, so WAIT samples it from its first cycle.
- The core has no reset of its own. Every job, including the first after `rst_n` and any job following a timeout, restarts it through `core_r_enable`.
- `core_init_*` hold their value from the pop until the next pop.

## Timing
- Reset values:
  - State IDLE, FIFO empty.
  - `job_ready` = 1, `job_count` = 0, `busy` = 0.
  - `core_r_enable` = 0, `core_init_i` = 0, `core_init_acc` = 0.
  - `res_valid` = 0, `res_data` = 0, `res_timeout` = 0.
- Reset asserted mid-job: all of the above take effect immediately (asynchronously). The queued jobs and the in-flight result are discarded, and no `core_r_enable` is issued.
- Latency, for a job accepted at edge E into an empty FIFO with the FSM in IDLE:
  - Pop at E+1.
  - `core_r_enable` high between E+1 and E+2.
  - First WAIT cycle starts at E+2.
  - If the core raises `w_enable` after k WAIT cycles, `res_valid` rises at E+2+k.
- Back-to-back jobs: the next job's LAUNCH starts at most 2 cycles after the result handshake (the IDLE cycle, then LAUNCH).
- `res_valid` is never deasserted without a handshake. `res_data` is stable while `res_valid` is high.
- The timeout fires on the `TIMEOUT`-th WAIT cycle, counting the first WAIT cycle as 1.

## Test plan
- **Single job:** push (i=0, acc=5); core stub raises `w_enable` after 10 cycles with result 0x1234. Expect:
  - one `core_r_enable` pulse, with `core_init_i` = 0 and `core_init_acc` = 5;
  - `res_valid` with `res_data` = 0x1234 and `res_timeout` = 0, 12 cycles after acceptance.
- **FIFO fill:** push 5 jobs back-to-back with `JOB_DEPTH` = 4 and the core stalled. Expect:
  - `job_ready` falls once `job_count` reaches 4;
  - the 5th job is accepted only after the first pop;
  - jobs are launched in FIFO order.
- **Stale done:** the core stub holds `w_enable` = 1 across the next LAUNCH, then drops it for 3 cycles. Expect no early completion; the result is captured only at the new `w_enable` rise.
- **Timeout:** `TIMEOUT` = 20, core never finishes. Expect `res_valid` with `res_timeout` = 1 and `res_data` = 0 exactly after 20 WAIT cycles; the next job issues a fresh `r_enable`.
- **Backpressure:** hold `res_ready` = 0 for 7 cycles. Expect:
  - `res_valid` and `res_data` stable throughout;
  - no new launch until the handshake;
  - the queued job launches 2 cycles after the handshake.
- **Reset mid-WAIT:** pulse `rst_n` low in the 4th WAIT cycle with 2 jobs queued. Expect all outputs at their reset values immediately, `job_count` = 0, and no further `core_r_enable` until a new push.
